// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider: default widths and FSM state encoding.
package div_pkg;

  localparam int DEF_DIV_WD = 32;
  localparam int DEF_CNT_WD = 5;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ITER = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step import div_pkg::*; #(
  parameter int DIV_WD = DEF_DIV_WD
) (
  input  logic [DIV_WD-1:0] rem,
  input  logic              dvd_bit,
  input  logic [DIV_WD-1:0] divisor,
  output logic [DIV_WD-1:0] rem_next,
  output logic              q_bit
);

  logic [DIV_WD:0] trial;

  // rem < divisor, so rem[DIV_WD-1] can only be set after the final step; dropping it is exact.
  always_comb begin
    trial    = {1'b0, rem[DIV_WD-2:0], dvd_bit} - {1'b0, divisor};
    q_bit    = ~trial[DIV_WD];
    rem_next = q_bit ? trial[DIV_WD-1:0] : {rem[DIV_WD-2:0], dvd_bit};
  end

endmodule

// File: rtl/div_top.sv
// Iterative signed/unsigned 32-bit divider: 32 restoring steps on magnitudes, one sign fix-up cycle.
module div_top import div_pkg::*; #(
  parameter int DIV_WD = DEF_DIV_WD,
  parameter int CNT_WD = DEF_CNT_WD
) (
  input  logic              div_clk,
  input  logic              reset,
  input  logic              div_valid,
  output logic              div_ready,
  input  logic              div_signed,
  input  logic [DIV_WD-1:0] src1,
  input  logic [DIV_WD-1:0] src2,
  input  logic              flush,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [DIV_WD-1:0] quotient,
  output logic [DIV_WD-1:0] remainder
);

  div_state_t        state, state_next;
  logic              armed;
  logic              accept;
  logic [CNT_WD-1:0] cnt;
  logic [DIV_WD-1:0] dvd, rem, divisor;
  logic              sign_q, sign_r, zero;
  logic              s1, s2;
  logic [DIV_WD-1:0] mag1, mag2;
  logic [DIV_WD-1:0] step_rem;
  logic              step_q;

  // armed keeps div_ready low during reset without a combinational path from the reset pin.
  assign div_ready = (state == DIV_IDLE) && armed;

  always_comb begin
    s1   = div_signed & src1[DIV_WD-1];
    s2   = div_signed & src2[DIV_WD-1];
    mag1 = s1 ? -src1 : src1;
    mag2 = s2 ? -src2 : src2;
  end

  always_ff @(posedge div_clk) begin
    if (reset) state <= DIV_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    if (flush) begin
      state_next = DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: if (div_valid && armed) begin
          accept     = 1'b1;
          state_next = DIV_ITER;
        end
        DIV_ITER: if (cnt == '0) state_next = DIV_FIX;
        DIV_FIX:  state_next = DIV_DONE;
        DIV_DONE: if (result_ready) state_next = DIV_IDLE;
        default:  state_next = DIV_IDLE;
      endcase
    end
  end

  div_step #(.DIV_WD(DIV_WD)) u_step (
    .rem      (rem),
    .dvd_bit  (dvd[DIV_WD-1]),
    .divisor  (divisor),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  always_ff @(posedge div_clk) begin
    if (reset) begin
      armed        <= 1'b0;
      cnt          <= '0;
      dvd          <= '0;
      rem          <= '0;
      divisor      <= '0;
      sign_q       <= 1'b0;
      sign_r       <= 1'b0;
      zero         <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      result_valid <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (flush) begin
        result_valid <= 1'b0;
      end else begin
        case (state)
          DIV_IDLE: if (accept) begin
            // A zero divisor keeps the raw dividend: 32 steps against 0 then return it unchanged.
            dvd     <= (src2 == '0) ? src1 : mag1;
            divisor <= mag2;
            rem     <= '0;
            sign_q  <= s1 ^ s2;
            sign_r  <= s1;
            zero    <= (src2 == '0);
            cnt     <= '1;
          end
          DIV_ITER: begin
            rem <= step_rem;
            dvd <= {dvd[DIV_WD-2:0], step_q};
            cnt <= cnt - CNT_WD'(1);
          end
          DIV_FIX: begin
            quotient     <= (sign_q && !zero) ? -dvd : dvd;
            remainder    <= (sign_r && !zero) ? -rem : rem;
            result_valid <= 1'b1;
          end
          DIV_DONE: if (result_ready) result_valid <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule
